// File: rtl/ssc_controller.sv
`default_nettype none
// ============================================================================
// Module   : ssc_controller
// Purpose  : Sequencer for an in-place ascending selection sort over N words.
// Revision : 1.0
// ============================================================================
module ssc_controller #(
    parameter int N       = 8,
    parameter int AW      = 8,
    parameter int ACC_CYC = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cnt1_out,
    output logic [AW-1:0] cnt2_out,
    output logic          load_temp,
    output logic          sel_mux,
    output logic [1:0]    Sel_AMux,
    output logic          Sel_DMux,
    output logic          Load_min,
    output logic          mem_we
);

    localparam int SW = $clog2(ACC_CYC);

    localparam logic [SW-1:0] c_step_last = SW'(ACC_CYC - 1);
    localparam logic [SW-1:0] c_step_pre  = SW'(ACC_CYC - 2);
    localparam logic [AW-1:0] c_last_j    = AW'(N - 1);
    localparam logic [AW-1:0] c_last_i    = AW'((N > 1) ? (N - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_I = 3'd1,
        S_SCAN   = 3'd2,
        S_WR_MIN = 3'd3,
        S_WR_I   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_step;
    logic [AW-1:0]   r_cnt1;
    logic [AW-1:0]   r_cnt2;
    logic            r_busy;
    logic            r_done;
    logic            r_load_temp;
    logic            r_sel_mux;
    logic [1:0]      r_sel_amux;
    logic            r_sel_dmux;
    logic            r_load_min;
    logic            r_mem_we;

    logic            w_last;
    logic            w_pre;
    logic [SW-1:0]   w_step_inc;

    assign w_last     = (r_step == c_step_last);
    assign w_pre      = (r_step == c_step_pre);
    assign w_step_inc = r_step + SW'(1);

    // Outputs are registered alongside the state; strobes are raised one
    // cycle early (step ACC_CYC-2) so they are visible on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_cnt1      <= '0;
            r_cnt2      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_load_temp <= 1'b0;
            r_sel_mux   <= 1'b0;
            r_sel_amux  <= 2'b00;
            r_sel_dmux  <= 1'b0;
            r_load_min  <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_load_temp <= 1'b0;
            r_load_min  <= 1'b0;
            r_mem_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_step <= '0;
                    if (start) begin
                        if (N == 1) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD_I;
                            r_cnt1     <= '0;
                            r_cnt2     <= AW'(1);
                            r_busy     <= 1'b1;
                            r_sel_mux  <= 1'b0;
                            r_sel_amux <= 2'b00;
                            r_sel_dmux <= 1'b0;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (w_last) begin
                        r_state    <= S_SCAN;
                        r_step     <= '0;
                        r_sel_mux  <= 1'b1;
                        r_sel_amux <= 2'b01;
                    end else begin
                        r_step      <= w_step_inc;
                        r_load_min  <= w_pre;
                        r_load_temp <= w_pre;
                    end
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_step <= '0;
                        if (r_cnt2 == c_last_j) begin
                            r_state    <= S_WR_MIN;
                            r_sel_mux  <= 1'b0;
                            r_sel_amux <= 2'b10;
                            r_sel_dmux <= 1'b1;
                        end else begin
                            r_cnt2 <= r_cnt2 + AW'(1);
                        end
                    end else begin
                        r_step <= w_step_inc;
                    end
                end
                S_WR_MIN: begin
                    if (w_last) begin
                        r_state    <= S_WR_I;
                        r_step     <= '0;
                        r_sel_amux <= 2'b00;
                        r_sel_dmux <= 1'b0;
                    end else begin
                        r_step   <= w_step_inc;
                        r_mem_we <= w_pre;
                    end
                end
                S_WR_I: begin
                    if (w_last) begin
                        r_step <= '0;
                        if (r_cnt1 == c_last_i) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_sel_mux  <= 1'b0;
                            r_sel_amux <= 2'b00;
                            r_sel_dmux <= 1'b0;
                        end else begin
                            r_state    <= S_LOAD_I;
                            r_cnt1     <= r_cnt1 + AW'(1);
                            r_cnt2     <= r_cnt1 + AW'(2);
                            r_sel_mux  <= 1'b0;
                            r_sel_amux <= 2'b00;
                            r_sel_dmux <= 1'b0;
                        end
                    end else begin
                        r_step   <= w_step_inc;
                        r_mem_we <= w_pre;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_step  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_step  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign cnt1_out  = r_cnt1;
    assign cnt2_out  = r_cnt2;
    assign load_temp = r_load_temp;
    assign sel_mux   = r_sel_mux;
    assign Sel_AMux  = r_sel_amux;
    assign Sel_DMux  = r_sel_dmux;
    assign Load_min  = r_load_min;
    assign mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_ssc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssc_controller
// Purpose  : Directed bench for ssc_controller with a small behavioural datapath.
// Revision : 1.0
// ============================================================================
module tb_ssc_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start1;

    logic       busy, done, load_temp, sel_mux, Sel_DMux, Load_min, mem_we;
    logic [7:0] cnt1_out, cnt2_out;
    logic [1:0] Sel_AMux;

    logic       busy1, done1, load_temp1, sel_mux1, Sel_DMux1, Load_min1, mem_we1;
    logic [7:0] cnt1_out1, cnt2_out1;
    logic [1:0] Sel_AMux1;

    int checks   = 0;
    int failures = 0;

    ssc_controller #(.N(4), .AW(8), .ACC_CYC(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cnt1_out(cnt1_out), .cnt2_out(cnt2_out), .load_temp(load_temp),
        .sel_mux(sel_mux), .Sel_AMux(Sel_AMux), .Sel_DMux(Sel_DMux),
        .Load_min(Load_min), .mem_we(mem_we)
    );

    ssc_controller #(.N(1), .AW(8), .ACC_CYC(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .cnt1_out(cnt1_out1), .cnt2_out(cnt2_out1), .load_temp(load_temp1),
        .sel_mux(sel_mux1), .Sel_AMux(Sel_AMux1), .Sel_DMux(Sel_DMux1),
        .Load_min(Load_min1), .mem_we(mem_we1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sort datapath: memory, min/min_addr, temp and comparator
    logic [7:0] mem [4];
    logic [7:0] init_d [4];
    logic       ld;
    logic [7:0] r_min, r_temp, r_min_addr;
    logic [7:0] w_addr;
    logic [1:0] w_a2, w_j2;

    assign w_addr = (Sel_AMux == 2'b00) ? cnt1_out :
                    (Sel_AMux == 2'b01) ? cnt2_out : r_min_addr;
    assign w_a2   = w_addr[1:0];
    assign w_j2   = cnt2_out[1:0];

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 4; i++) mem[i] <= init_d[i];
        end else if (mem_we) begin
            mem[w_a2] <= Sel_DMux ? r_temp : r_min;
        end
        if (Load_min) begin
            r_min      <= mem[w_a2];
            r_min_addr <= sel_mux ? cnt2_out : cnt1_out;
        end else if (sel_mux && (mem[w_j2] < r_min)) begin
            r_min      <= mem[w_j2];
            r_min_addr <= cnt2_out;
        end
        if (load_temp) r_temp <= mem[w_a2];
    end

    int busy_cnt, done_cnt, we_cnt, busy1_cnt, we1_cnt;
    bit moved;

    always @(negedge clk) begin
        if (busy)    busy_cnt++;
        if (done)    done_cnt++;
        if (mem_we)  we_cnt++;
        if (sel_mux && (r_min_addr != cnt1_out)) moved = 1'b1;
        if (busy1)   busy1_cnt++;
        if (mem_we1) we1_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        busy_cnt = 0; done_cnt = 0; we_cnt = 0; moved = 1'b0;
    endtask

    task automatic load_mem(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        init_d[0] = a; init_d[1] = b; init_d[2] = c; init_d[3] = d;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_done(input int mid_start, input bit hold);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (mid_start > 0 && k == mid_start) start = 1'b1;
            else if (!hold)                      start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk_eq("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic check_run(input string tag, input logic [31:0] exp_mem,
                             input int exp_busy, input int exp_done, input int exp_we);
        @(negedge clk);
        chk_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        chk_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
        chk_eq({tag, "_we_pulses"},   32'(we_cnt),   32'(exp_we));
        chk_eq({tag, "_mem"}, {mem[0], mem[1], mem[2], mem[3]}, exp_mem);
    endtask

    function automatic logic [31:0] outs0();
        return {7'd0, busy, done, load_temp, sel_mux, Sel_AMux, Sel_DMux,
                Load_min, mem_we, cnt1_out, cnt2_out};
    endfunction

    function automatic logic [31:0] outs1();
        return {7'd0, busy1, done1, load_temp1, sel_mux1, Sel_AMux1, Sel_DMux1,
                Load_min1, mem_we1, cnt1_out1, cnt2_out1};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; ld = 1'b0;
        for (int i = 0; i < 4; i++) init_d[i] = 8'd0;
        busy1_cnt = 0; we1_cnt = 0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk_eq("reset_outs", outs0(), 32'd0);
        chk_eq("reset_outs_n1", outs1(), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sort: 3 passes of 6,5,4 steps x 3 cycles
        load_mem(8'd3, 8'd1, 8'd4, 8'd2);
        clear_mon();
        start = 1'b1;
        wait_done(0, 1'b0);
        check_run("basic", {8'd1, 8'd2, 8'd3, 8'd4}, 45, 1, 6);

        load_mem(8'd1, 8'd2, 8'd3, 8'd4);
        clear_mon();
        start = 1'b1;
        wait_done(0, 1'b0);
        check_run("sorted", {8'd1, 8'd2, 8'd3, 8'd4}, 45, 1, 6);
        chk_eq("sorted_min_addr_stays", 32'(moved), 32'd0);

        load_mem(8'd5, 8'd5, 8'd5, 8'd5);
        clear_mon();
        start = 1'b1;
        wait_done(0, 1'b0);
        check_run("equal", {8'd5, 8'd5, 8'd5, 8'd5}, 45, 1, 6);
        chk_eq("equal_min_addr_stays", 32'(moved), 32'd0);

        // Second start pulse lands in the first SCAN of pass 0
        load_mem(8'd9, 8'd7, 8'd8, 8'd6);
        clear_mon();
        start = 1'b1;
        wait_done(6, 1'b0);
        check_run("midstart", {8'd6, 8'd7, 8'd8, 8'd9}, 45, 1, 6);

        // Reset asserted for one cycle during SCAN
        load_mem(8'd4, 8'd3, 8'd2, 8'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk_eq("midrun_in_scan", 32'(Sel_AMux), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("midrun_reset_outs", outs0(), 32'd0);
        @(negedge clk);
        chk_eq("midrun_idle_after", outs0(), 32'd0);
        load_mem(8'd4, 8'd3, 8'd2, 8'd1);
        clear_mon();
        start = 1'b1;
        wait_done(0, 1'b0);
        check_run("after_reset", {8'd1, 8'd2, 8'd3, 8'd4}, 45, 1, 6);

        // Start held high through DONE relaunches a sort
        load_mem(8'd2, 8'd1, 8'd4, 8'd3);
        clear_mon();
        start = 1'b1;
        wait_done(0, 1'b1);
        @(negedge clk);
        chk_eq("relaunch_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk_eq("relaunch_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(0, 1'b0);
        check_run("relaunch", {8'd1, 8'd2, 8'd3, 8'd4}, 90, 2, 12);

        // Single-word sort completes immediately
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk_eq("n1_done", 32'(done1), 32'd1);
        chk_eq("n1_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        chk_eq("n1_done_cleared", 32'(done1), 32'd0);
        repeat (2) @(negedge clk);
        chk_eq("n1_never_busy", 32'(busy1_cnt), 32'd0);
        chk_eq("n1_no_we", 32'(we1_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
